if_fetch: RTL



---
 rtl/if_fetch_pkg.sv | 17 +
 rtl/if_fifo.sv | 64 ++++++
 rtl/if_fetch.sv | 110 +++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit and its prefetch FIFO.
// Holds the NOP encoding, the default reset PC and the FIFO entry layout.
package if_fetch_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous prefetch FIFO of {addr, inst} entries with push, pop, flush and occupancy.
// Storage is registered, so a word pushed in cycle N is visible at the head in cycle N+1.
module if_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t data_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    assign do_push = push_i && !flush_i && !rst;
    assign do_pop  = pop_i && !flush_i && !empty_o;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    // Flush empties the queue in one edge; stale storage is simply overwritten later.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC generation, credit-limited memory requests, response tagging,
// prefetch buffering and redirect handling toward the decode stage.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic [31:0]   jump_tgt;
    logic          grant, push, pop;
    logic          fifo_empty, fifo_full;
    fetch_entry_t  push_entry, head;

    assign jump_tgt = word_align(jump_addr_i);

    // In-flight requests plus buffered words may never exceed the FIFO depth,
    // which is what makes an overflowing push impossible.
    assign credit_used = {1'b0, outst_q} + {1'b0, fifo_count};
    assign imem_req_o  = !rst && !jump_en_i && (credit_used < DEPTH_W);
    assign imem_addr_o = pc_q;
    assign grant       = imem_req_o && imem_gnt_i;

    assign push       = imem_rvalid_i && !jump_en_i && (discard_q == '0);
    assign push_entry = '{addr: rsp_pc_q, inst: imem_rdata_i};

    assign inst_valid_o = !fifo_empty && !jump_en_i;
    assign pop          = inst_valid_o && inst_ready_i;
    assign inst_o       = inst_valid_o ? head.inst : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? head.addr : '0;

    always_comb begin
        pc_d      = pc_q;
        rsp_pc_d  = rsp_pc_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        if (grant && !imem_rvalid_i)      outst_d = outst_q + CW'(1);
        else if (!grant && imem_rvalid_i) outst_d = outst_q - CW'(1);
        if (jump_en_i) begin
            // Everything still in flight belongs to the old path, except a response
            // landing right now, which is dropped here directly.
            pc_d      = jump_tgt;
            rsp_pc_d  = jump_tgt;
            discard_d = outst_q - (imem_rvalid_i ? CW'(1) : CW'(0));
        end else begin
            if (grant) pc_d = pc_q + 32'd4;
            if (push)               rsp_pc_d  = rsp_pc_q + 32'd4;
            else if (imem_rvalid_i) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            rsp_pc_q  <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            rsp_pc_q  <= rsp_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_push_not_full: assert (!(push && fifo_full));
        end
    end

    if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (jump_en_i),
        .data_i  (push_entry),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
